uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised oversampling UART receiver, successor to the fixed 8N1 16x receiver.
- Generalised data width, oversample ratio, stop-bit count and sample-rate prescaler.
- Adds input synchroniser, valid/ready output handshake, overrun and framing-error reporting, and break recovery.
- Sits between the serial RX pin and the VU-meter sample consumer.

Parameters:
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- OVS, 16: samples per bit; even, >= 4.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- CLKS_PER_SAMPLE, 1: clk cycles per sample tick; 1 = sample every clk.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx  in  1  serial input, idle high; asynchronous to clk.
- data  out  DATA_BITS  received word; valid while data_valid=1.
- data_valid  out  1  word available.
- data_ready  in  1  consumer accepts word when data_valid&data_ready.
- frame_err  out  1  1-cycle pulse, stop bit sampled low.
- parity_err  out  1  1-cycle pulse (tied 0 without UART_RX_PARITY_EN).
- overrun  out  1  1-cycle pulse, new word lost because holding register full.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: data=0, data_valid=0, all error pulses=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s).
  - All decisions use rx_s.
  - Adds 2 clk latency.
- Prescaler: tick every CLKS_PER_SAMPLE clks. Restarts on the IDLE->START transition so sampling aligns to the start edge.
- Sample counter: 0..OVS-1, advances on tick, wraps to 0 at each bit boundary.
- Majority vote:
  - rx_s is captured at counts OVS/2-1, OVS/2 and OVS/2+1.
  - Vote is 2-of-3, evaluated at count OVS-1 (end of bit).
- States:
  - IDLE: rx_s=0 -> START, counters cleared.
  - START: at end of bit, vote=0 -> DATA; vote=1 -> IDLE (glitch rejected, no error pulse).
  - DATA: at each end of bit, the vote is shifted in LSB-first. After DATA_BITS bits -> PARITY if enabled, else STOP.
  - PARITY: at end of bit, compare vote against the computed parity -> STOP.
  - STOP: checks STOP_BITS bits.
    - All votes 1 -> deliver word -> IDLE.
    - Any vote 0 -> frame_err pulse, word discarded -> BREAK.
  - BREAK: wait for rx_s=1 on any clk -> IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Delivery: occurs on the clk after the last stop-bit evaluation.
  - Holding register empty, or emptied in the same cycle by data_valid&data_ready: data loads and data_valid=1, no overrun.
  - Full and not accepted: old data kept, data_valid stays 1, overrun pulses 1 cycle.
- data_valid clears the cycle after data_valid&data_ready unless a new word is loaded in that same cycle.
- Parity error: the word is still delivered and parity_err pulses with the delivery.
- Reset mid-frame: immediate return to IDLE. Partial word and holding register are discarded.
- Nominal latency: the word appears 2 clk (sync) + 1 clk after the last stop sample point.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Parameter PARITY_ODD (default 0 = even) is added.
  - The PARITY state samples one parity bit after the data bits.
  - A mismatch pulses parity_err together with the data_valid rise.
- Undefined:
  - No PARITY state.
  - Frame is start + DATA_BITS + STOP_BITS.
  - parity_err is constant 0.

Test Plan:
- 8N1, OVS=16, CLKS_PER_SAMPLE=1: send 0xA5 with data_ready=1 -> data=0xA5, data_valid high for exactly 1 clk, no error pulses.
- Start glitch: rx low for 5 clks, then high -> state returns to IDLE, busy drops after 16 ticks, no data_valid, no frame_err.
- Stop bit forced low on 0x3C, then line held low 40 bit times, then high, then 0x81 sent -> one frame_err pulse, no data_valid during low period, 0x81 received correctly.
- data_ready=0: send 0x11 then 0x22 -> data stays 0x11, data_valid=1, one overrun pulse. Raise data_ready -> data_valid clears next clk.
- Noise tolerance: 0x55 with one inverted sample at count 7 of each bit -> data=0x55. Also DATA_BITS=7, STOP_BITS=2, CLKS_PER_SAMPLE=4 with 0x7F -> data=0x7F.
- UART_RX_PARITY_EN, even parity: 0x03 with parity bit 1 -> data=0x03 plus parity_err pulse. Assert rst mid-data-bit -> all outputs 0 next clk, the following frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-flop sync, 2-of-3 mid-bit vote, break recovery.
// Defining UART_RX_PARITY_EN adds a parity bit check (PARITY_ODD selects odd parity).
module uart_rx_param #(
    parameter int DATA_BITS       = 8,
    parameter int OVS             = 16,
    parameter int STOP_BITS       = 1,
    parameter int CLKS_PER_SAMPLE = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD      = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int SW = $clog2(OVS);
    localparam int PW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SMP_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] SMP_V0   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SMP_V1   = SW'(OVS / 2);
    localparam logic [SW-1:0] SMP_V2   = SW'(OVS / 2 + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [SW-1:0]        smp_q, smp_d;
    logic [2:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;

    logic tick, eob, v2, vote, deliver;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick = (pre_q == PRE_LAST);
    assign eob  = tick && (smp_q == SMP_LAST);
    // With OVS=4 the third vote sample lands on the end-of-bit tick itself.
    assign v2   = (smp_q == SMP_V2) ? rx_s_q : vote_q[2];
    assign vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & v2) | (vote_q[1] & v2);

    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + 1'b1;
        smp_d     = smp_q;
        vote_d    = vote_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        par_bad_d = par_bad_q;
        deliver   = 1'b0;
        ferr_d    = 1'b0;
        if (state_q == S_IDLE) begin
            smp_d = '0;
            bit_d = '0;
            stop_d = 1'b0;
            if (!rx_s_q) begin
                state_d = S_START;
                pre_d   = '0;
            end
        end else if (state_q == S_BREAK) begin
            if (rx_s_q) state_d = S_IDLE;
        end else if (tick) begin
            smp_d = eob ? '0 : smp_q + 1'b1;
            if (smp_q == SMP_V0) vote_d[0] = rx_s_q;
            if (smp_q == SMP_V1) vote_d[1] = rx_s_q;
            if (smp_q == SMP_V2) vote_d[2] = rx_s_q;
            if (eob) begin
                case (state_q)
                    S_START: state_d = vote ? S_IDLE : S_DATA;
                    S_DATA: begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        par_bad_d = vote != ((^shift_q) ^ PARITY_ODD);
                        state_d   = S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (!vote) begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end else if (stop_q == STP_LAST) begin
                            deliver = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~data_ready;
        ovr_d   = 1'b0;
        perr_d  = 1'b0;
        if (deliver) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = par_bad_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            smp_q     <= '0;
            vote_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            smp_q     <= smp_d;
            vote_q    <= vote_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1/16x instance plus a 7-bit, 2-stop, 4-clk-prescaled instance.
// Frames are built bit by bit from random words; a word queue model predicts deliveries.
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rx1, rdy1, dv1, fe1, pe1, ov1, bz1;
    logic [7:0] d1;
    logic rx2, rdy2, dv2, fe2, pe2, ov2, bz2;
    logic [6:0] d2;

    always #5 clk = ~clk;

    uart_rx_param dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(d1), .data_valid(dv1),
        .data_ready(rdy1), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .busy(bz1)
    );

    uart_rx_param #(
        .DATA_BITS(7), .OVS(16), .STOP_BITS(2), .CLKS_PER_SAMPLE(4)
    ) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .data(d2), .data_valid(dv2),
        .data_ready(rdy2), .frame_err(fe2), .parity_err(pe2),
        .overrun(ov2), .busy(bz2)
    );

    // Monitor: logs accepted words and counts output pulses.
    logic [8:0] got1 [256];
    logic [8:0] got2 [256];
    int got_n1 = 0, got_n2 = 0;
    int vc1 = 0, fc1 = 0, pc1 = 0, oc1 = 0;
    int vc2 = 0, fc2 = 0;

    always @(negedge clk) begin
        if (dv1 && rdy1) begin
            got1[got_n1[7:0]] <= {1'b0, d1};
            got_n1 <= got_n1 + 1;
        end
        if (dv2 && rdy2) begin
            got2[got_n2[7:0]] <= {2'b0, d2};
            got_n2 <= got_n2 + 1;
        end
        vc1 <= vc1 + 32'(dv1);
        fc1 <= fc1 + 32'(fe1);
        pc1 <= pc1 + 32'(pe1);
        oc1 <= oc1 + 32'(ov1);
        vc2 <= vc2 + 32'(dv2);
        fc2 <= fc2 + 32'(fe2);
    end

    int n_tests = 0, n_fail = 0;
    logic [8:0] exp1[$];
    logic [8:0] exp2[$];
    bit held1;
    int ov_exp1 = 0;
    int rd1 = 0, rd2 = 0;
    int v0, f0, o0, p0, oe0;
    logic [7:0] b8;
    logic [6:0] b7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) rx1 = v;
        else rx2 = v;
    endtask

    task automatic idle(input int w, input int cycles);
        drive(w, 1'b1);
        repeat (cycles) @(negedge clk);
    endtask

    // Serialise one frame; stop_low forces the last stop bit low,
    // noise inverts one sample in the first half of every bit.
    task automatic send(input int w, input logic [8:0] d, input int nb,
                        input int ns, input int bclk, input logic pbit,
                        input bit stop_low, input bit noise);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 1;
        for (int i = 0; i < nb; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (PEN) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = !(stop_low && i == ns - 1);
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < bclk; c++) begin
                drive(w, (noise && c == bclk / 2) ? ~bits[b] : bits[b]);
                @(negedge clk);
            end
        end
        if (!stop_low) begin
            if (w == 0) begin
                if (held1 && !rdy1) ov_exp1++;
                else begin
                    exp1.push_back(d);
                    held1 = !rdy1;
                end
            end else begin
                exp2.push_back(d);
            end
        end
    endtask

    task automatic drain1(input string tag);
        chk({tag, "_cnt"}, got_n1 - rd1, exp1.size());
        while (exp1.size() > 0 && rd1 < got_n1) begin
            chk({tag, "_data"}, got1[rd1[7:0]], exp1.pop_front());
            rd1++;
        end
        exp1.delete();
        rd1 = got_n1;
    endtask

    task automatic drain2(input string tag);
        chk({tag, "_cnt"}, got_n2 - rd2, exp2.size());
        while (exp2.size() > 0 && rd2 < got_n2) begin
            chk({tag, "_data"}, got2[rd2[7:0]], exp2.pop_front());
            rd2++;
        end
        exp2.delete();
        rd2 = got_n2;
    endtask

    initial begin
        rst = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        held1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", d1, 0);
        chk("rst_valid", dv1, 0);
        chk("rst_ferr", fe1, 0);
        chk("rst_perr", pe1, 0);
        chk("rst_ovr", ov1, 0);
        chk("rst_busy", bz1, 0);
        chk("rst_valid2", dv2, 0);
        chk("rst_busy2", bz2, 0);
        rst = 1'b0;
        idle(0, 10);

        // Clean frames: 0xA5 then random words.
        v0 = vc1; f0 = fc1; o0 = oc1; p0 = pc1;
        for (int k = 0; k < 6; k++) begin
            b8 = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
            idle(0, 32);
            drain1($sformatf("byte%0d", k));
        end
        chk("valid_one_clk_each", vc1 - v0, 6);
        chk("clean_no_ferr", fc1 - f0, 0);
        chk("clean_no_ovr", oc1 - o0, 0);
        chk("clean_no_perr", pc1 - p0, 0);

        // One inverted sample per bit must be outvoted.
        for (int k = 0; k < 4; k++) begin
            b8 = (k == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b1);
            idle(0, 32);
            drain1($sformatf("noise%0d", k));
        end

        // Short start glitch is rejected silently.
        v0 = vc1; f0 = fc1;
        for (int c = 0; c < 5; c++) begin
            rx1 = 1'b0;
            @(negedge clk);
        end
        rx1 = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_busy_hold", bz1, 1);
        repeat (4) @(negedge clk);
        chk("glitch_busy_drop", bz1, 0);
        idle(0, 16);
        chk("glitch_no_valid", vc1 - v0, 0);
        chk("glitch_no_ferr", fc1 - f0, 0);

        // Framing error then a line held low for 40 bit times.
        v0 = vc1; f0 = fc1;
        b8 = 8'h3C;
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b1, 1'b0);
        repeat (640) @(negedge clk);
        chk("break_no_valid", vc1 - v0, 0);
        chk("break_ferr_once", fc1 - f0, 1);
        chk("break_busy", bz1, 1);
        idle(0, 32);
        chk("break_recovered", bz1, 0);
        b8 = 8'h81;
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        drain1("after_break");
        chk("after_break_ferr", fc1 - f0, 1);

        // Overrun with consumer stalled.
        @(posedge clk);
        #1 rdy1 = 1'b0;
        @(negedge clk);
        o0 = oc1; oe0 = ov_exp1;
        b8 = 8'h11;
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        b8 = 8'h22;
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        chk("ovr_data_kept", d1, 8'h11);
        chk("ovr_valid_held", dv1, 1);
        chk("ovr_pulse", oc1 - o0, ov_exp1 - oe0);
        @(posedge clk);
        #1 rdy1 = 1'b1;
        held1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ovr_valid_clear", dv1, 0);
        drain1("ovr_word");

        // Reset mid-data-bit with a word still held.
        @(posedge clk);
        #1 rdy1 = 1'b0;
        @(negedge clk);
        b8 = 8'($urandom_range(0, 255));
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        chk("prerst_valid", dv1, 1);
        b8 = 8'($urandom_range(0, 255));
        for (int c = 0; c < 56; c++) begin
            rx1 = (c < 16) ? 1'b0 : b8[(c - 16) / 16];
            @(negedge clk);
        end
        chk("prerst_busy", bz1, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", dv1, 0);
        chk("midrst_data", d1, 0);
        chk("midrst_busy", bz1, 0);
        chk("midrst_ferr", fe1, 0);
        chk("midrst_ovr", ov1, 0);
        @(negedge clk);
        rst = 1'b0;
        rx1 = 1'b1;
        rdy1 = 1'b1;
        held1 = 1'b0;
        exp1.delete();
        rd1 = got_n1;
        idle(0, 32);
        b8 = 8'($urandom_range(0, 255));
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        drain1("postrst");

        // 7 data bits, 2 stop bits, 4 clks per sample.
        idle(1, 16);
        v0 = vc2; f0 = fc2;
        for (int k = 0; k < 3; k++) begin
            b7 = (k == 0) ? 7'h7F : 7'($urandom_range(0, 127));
            send(1, {2'b0, b7}, 7, 2, 64, ^b7, 1'b0, 1'b0);
            idle(1, 160);
            drain2($sformatf("w7_%0d", k));
        end
        chk("w7_valid_cycles", vc2 - v0, 3);
        b7 = 7'($urandom_range(0, 127));
        send(1, {2'b0, b7}, 7, 2, 64, ^b7, 1'b1, 1'b0);
        idle(1, 160);
        chk("w7_ferr_2nd_stop", fc2 - f0, 1);
        chk("w7_no_valid_on_ferr", vc2 - v0, 3);
        chk("w7_idle", bz2, 0);

`ifdef UART_RX_PARITY_EN
        p0 = pc1;
        b8 = 8'h03;
        send(0, {1'b0, b8}, 8, 1, 16, 1'b1, 1'b0, 1'b0);
        idle(0, 32);
        drain1("par_bad");
        chk("par_err_pulse", pc1 - p0, 1);
        b8 = 8'($urandom_range(0, 255));
        send(0, {1'b0, b8}, 8, 1, 16, ^b8, 1'b0, 1'b0);
        idle(0, 32);
        drain1("par_good");
        chk("par_no_err", pc1 - p0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
